// File: rtl/tri_mem_pkg.sv
// Shared types and constants for the triangle-fetch memory arbiter.
//   state_t   : arbiter FSM states
//   TRI_BEATS : halfword beats per triangle (9 coordinates x 2 halfwords)
//   COORD_W   : width of one triangle coordinate
//   next_idx  : wrapping increment used for the round-robin pointer
package tri_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int TRI_BEATS = 18;
  localparam int COORD_W   = 32;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index for this pick
//   grant : one-hot winner (all zero when no request)
//   gidx  : index of the winner (0 when no request)
// The winner is the first set bit at or after ptr, wrapping past N_REQ-1.
module rr_arbiter
  import tri_mem_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] gidx
);

  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr) + i) % N_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gidx        = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/tri_mem_arbiter.sv
// Shares one Avalon-MM read master among N_REQ triangle fetchers.
// A fetch is one accepted read followed by BEATS read-data beats; the grant
// is held from selection until the owner's last beat has been delivered.
//
// Handshake: a requester holds s_read/s_address until it sees s_read high
// with s_waitrequest low at a rising edge (accepted). Only the owner in ISSUE
// sees the master's waitrequest; everyone else is stalled. Read data is
// broadcast, so each requester must qualify it with its own s_readdatavalid.
//
// Ports:
//   i_clk, i_rstn     clock, asynchronous active-low reset
//   s_read/s_address  per-requester request and address (slice r*ADDR_W)
//   s_waitrequest     per-requester stall
//   s_readdata        broadcast read data
//   s_readdatavalid   per-requester data valid
//   m_*               shared Avalon-MM read master
//   o_owner           current or last grant index
//   o_busy            arbiter not idle
//   o_err             sticky: beat arrived while not draining
//   o_state           FSM state (debug)
module tri_mem_arbiter
  import tri_mem_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int BEATS  = TRI_BEATS
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [N_REQ-1:0]          s_read,
  input  logic [N_REQ*ADDR_W-1:0]   s_address,
  output logic [N_REQ-1:0]          s_waitrequest,
  output logic [DATA_W-1:0]         s_readdata,
  output logic [N_REQ-1:0]          s_readdatavalid,
  output logic                      m_read,
  output logic [ADDR_W-1:0]         m_address,
  output logic [DATA_W/8-1:0]       m_byteenable,
  input  logic [DATA_W-1:0]         m_readdata,
  input  logic                      m_readdatavalid,
  input  logic                      m_waitrequest,
  output logic [$clog2(N_REQ)-1:0]  o_owner,
  output logic                      o_busy,
  output logic                      o_err,
  output logic [1:0]                o_state
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t            state, state_nxt;
  logic [OW-1:0]     owner, rr_ptr, gidx, ptr_after;
  logic [CW-1:0]     beat_cnt;
  logic [N_REQ-1:0]  grant;
  logic [ADDR_W-1:0] sel_addr;
  logic              last_beat;
  logic              err;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(OW)) u_rr (
    .req   (s_read),
    .ptr   (rr_ptr),
    .grant (grant),
    .gidx  (gidx)
  );

  // Address of the winner, muxed by the one-hot grant.
  always_comb begin
    sel_addr = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant[r]) sel_addr = s_address[r*ADDR_W +: ADDR_W];
    end
  end

  assign last_beat = (state == DRAIN) && m_readdatavalid && (beat_cnt == CW'(BEATS - 1));
  assign ptr_after = OW'(next_idx(int'(owner), N_REQ));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    s_waitrequest   = '1;
    s_readdatavalid = '0;
    unique case (state)
      IDLE:  if (|s_read) state_nxt = ISSUE;
      ISSUE: begin
        s_waitrequest[owner] = m_waitrequest;
        if (!m_waitrequest) state_nxt = DRAIN;
      end
      DRAIN: begin
        s_readdatavalid[owner] = m_readdatavalid;
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      owner     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      m_read    <= 1'b0;
      m_address <= '0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (|s_read) begin
          owner     <= gidx;
          m_address <= sel_addr;
          m_read    <= 1'b1;
        end
        ISSUE: if (!m_waitrequest) begin
          m_read   <= 1'b0;
          beat_cnt <= '0;
        end
        DRAIN: if (m_readdatavalid) begin
          if (last_beat) begin
            beat_cnt <= '0;
            rr_ptr   <= ptr_after;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      // Beats with no fetch in flight are dropped; remember that it happened.
      if (m_readdatavalid && (state != DRAIN)) err <= 1'b1;
    end
  end

  assign s_readdata   = m_readdata;
  assign m_byteenable = '1;
  assign o_owner      = owner;
  assign o_busy       = (state != IDLE);
  assign o_err        = err;
  assign o_state      = state;

endmodule

// File: doc/tri_mem_arbiter.md
# tri_mem_arbiter

Shares one Avalon-MM read master (16-bit read data) among `N_REQ` `tri_insector` instances so that several rays can be tested against the triangle list in parallel. Each requester issues one triangle fetch at a time. A fetch is one accepted read followed by `BEATS` read-data beats. The arbiter grants requesters round-robin, holds the grant until the owner's last beat has been delivered, and isolates non-owners from the shared bus.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `ADDR_W`, 32, address width
- `DATA_W`, 16, read data width
- `BEATS`, 18, data beats per fetch (9 coordinates × 2 halfwords)

Ports:
- `i_clk`  in  1  clock
- `i_rstn`  in  1  asynchronous active-low reset
- `s_read`  in  `N_REQ`  per-requester read request; held until accepted
- `s_address`  in  `N_REQ*ADDR_W`  per-requester address; slice r is `[r*ADDR_W +: ADDR_W]`
- `s_waitrequest`  out  `N_REQ`  per-requester stall
- `s_readdata`  out  `DATA_W`  broadcast read data
- `s_readdatavalid`  out  `N_REQ`  per-requester data valid
- `m_read`  out  1  master read
- `m_address`  out  `ADDR_W`  master address
- `m_byteenable`  out  `DATA_W/8`  tied all-ones
- `m_readdata`  in  `DATA_W`  master read data
- `m_readdatavalid`  in  1  master data valid
- `m_waitrequest`  in  1  master stall
- `o_owner`  out  `$clog2(N_REQ)`  current or last grant index
- `o_busy`  out  1  state ≠ IDLE
- `o_err`  out  1  sticky: beat received outside DRAIN

## Operation
- States:
  - IDLE: no grant is active. If any `s_read` bit is set, the arbiter picks winner w, the first set bit at or after `rr_ptr` (wrapping). It latches `owner`=w, registers `m_address` from the address slice of w, sets `m_read`=1, and goes to ISSUE.
  - ISSUE: `m_read` is held high and `m_address` is held stable. When `m_waitrequest`=0 at a rising edge, the read is accepted: `m_read`→0, `beat_cnt`→0, go to DRAIN.
  - DRAIN: each cycle with `m_readdatavalid`=1 increments `beat_cnt`. On the beat where `beat_cnt`==`BEATS-1`: go to IDLE and set `rr_ptr` = (owner+1) mod `N_REQ`.
- `s_waitrequest[r]`:
  - = `m_waitrequest` when r==owner and state==ISSUE.
  - = 1 otherwise.
  - The owner therefore sees acceptance in the same cycle as the master does.
- `s_readdatavalid[r]` = `m_readdatavalid` when r==owner and state==DRAIN; 0 otherwise. This path is combinational (0 latency).
- `s_readdata` = `m_readdata` at all times. Non-owners must qualify data with their own valid.
- A requester that drops `s_read` before it is granted is simply skipped.
- `s_read` and `s_address` of the owner are ignored after grant. The address is the value latched in IDLE.
- `m_readdatavalid`=1 in IDLE or ISSUE: the beat is dropped, not forwarded, and sets `o_err`. `o_err` clears only on reset.
- `beat_cnt` width is `$clog2(BEATS)`. It never exceeds `BEATS-1`.

## Timing
- Reset (async assert, synchronous release). Reset values:
  - state=IDLE, `m_read`=0, `m_address`=0, `rr_ptr`=0, `owner`=0, `beat_cnt`=0.
  - `s_waitrequest`=all ones, `s_readdatavalid`=0, `o_busy`=0, `o_err`=0.
- Request to master read: `s_read` is sampled high in IDLE at edge k; `m_read`=1 from cycle k+1.
- With `m_waitrequest`=0 the read is accepted at edge k+1. The first beat may arrive in cycle k+2 or later.
- After the last beat, the arbiter is in IDLE the next cycle. The next grant issues `m_read` one cycle after that.
- Minimum gap between consecutive master reads: 1 IDLE cycle.
- Simultaneous requests: exactly one grant per IDLE visit, in round-robin order from `rr_ptr`.
- Reset mid-ISSUE or mid-DRAIN:
  - Everything returns to reset values immediately, including `rr_ptr`.
  - Beats still in flight from the master after reset are dropped and set `o_err`. Software must also reset the memory side.

## Structure
- Package `tri_mem_pkg`:
  - `state_t` enum {IDLE, ISSUE, DRAIN}.
  - `TRI_BEATS`=18 (default for `BEATS`).
  - `COORD_W`=32.
- Sub-module `rr_arbiter`: purely combinational.
  - Inputs `req[N_REQ]` and `ptr`; outputs one-hot `grant` and index `gidx`.
  - `tri_mem_arbiter` registers its result in IDLE.

## Test plan
- Single requester 0, addr 0x1000, `m_waitrequest`=0, memory returns 18 beats:
  - `m_read` high for exactly 1 cycle at 0x1000.
  - `s_readdatavalid[0]` pulses 18 times with matching data.
  - IDLE afterward; `rr_ptr`=1.
- Requesters 0, 1 and 3 assert together at `rr_ptr`=0:
  - Master addresses issue in order 0, 1, 3, each only after the previous 18th beat.
  - `rr_ptr` ends at 0 (wrap).
- `m_waitrequest` held high for 5 cycles in ISSUE:
  - `m_read` and `m_address` stay stable.
  - `s_waitrequest[owner]` is high for the 5 cycles, then low for 1 cycle; the transition to DRAIN follows.
- Non-owner isolation: during requester 2's DRAIN, requester 0 asserts read. Requester 0 sees `s_waitrequest`=1 and `s_readdatavalid`=0 until requester 2's 18th beat; it is granted next.
- `i_rstn` pulsed low after beat 7 of 18:
  - All outputs return to reset values asynchronously.
  - 3 trailing beats set `o_err`=1 and are not forwarded.
  - A new request completes normally afterward.
- `m_readdatavalid` pulsed in IDLE with no grant: no `s_readdatavalid` bit asserts; `o_err`=1.
